// File: rtl/simd_alu_sat_pipe.sv
// -----------------------------------------------------------------------------
// simd_alu_sat_pipe
//   Pipelined SIMD add/sub unit. DATA_WIDTH operand vectors are split into
//   8/16/32/64-bit lanes (selected per beat). Each lane adds or subtracts,
//   signed or unsigned, with wrap or saturate, and reports overflow/underflow
//   on the most-significant byte of the lane. A saturating counter tallies
//   flagged lanes on every accepted output beat.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake (transfer = in_valid & in_ready)
//   in_a, in_b            operand vectors
//   in_lane               lane size 0=8b 1=16b 2=32b 3=64b
//   in_sub                1: A-B, 0: A+B
//   in_signed             1: two's-complement lanes, 0: unsigned
//   in_sat                1: saturate, 0: wrap
//   out_valid / out_ready result handshake
//   out_data              per-lane results
//   out_ovf, out_udf      per-byte overflow / underflow flags
//   evt_cnt               saturating count of flagged lanes on output transfers
//   evt_clr               synchronous clear of evt_cnt (wins over increment)
// -----------------------------------------------------------------------------
module simd_alu_sat_pipe #(
  parameter int DATA_WIDTH  = 256,
  parameter int PIPE_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  input  logic [1:0]              in_lane,
  input  logic                    in_sub,
  input  logic                    in_signed,
  input  logic                    in_sat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [DATA_WIDTH/8-1:0] out_ovf,
  output logic [DATA_WIDTH/8-1:0] out_udf,
  output logic [CNT_WIDTH-1:0]    evt_cnt,
  input  logic                    evt_clr
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int NC = DATA_WIDTH / 64;
  localparam int PW = $clog2(NB + 1);
  localparam int SW = CNT_WIDTH + PW;

  // One 64-bit chunk holds whole lanes of every size, so lanes never straddle
  // chunks. Each lane is extended to 66 bits (sign or zero) so the exact
  // sum/difference is representable and range checks become plain compares.
  // Returns {udf[7:0], ovf[7:0], res[63:0]}.
  function automatic logic [79:0] chunk_op(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [1:0]  lane,
    input logic        sub,
    input logic        sgn,
    input logic        sat
  );
    int unsigned w;
    int unsigned nl;
    int unsigned bpl;
    logic [65:0] ax;
    logic [65:0] bx;
    logic [65:0] s;
    logic [65:0] maxv;
    logic [65:0] minv;
    logic [65:0] r;
    logic        o;
    logic        u;
    logic [63:0] res;
    logic [7:0]  ovf;
    logic [7:0]  udf;
    w   = 32'd8 << lane;
    nl  = 32'd64 / w;
    bpl = w / 32'd8;
    res = '0;
    ovf = '0;
    udf = '0;
    for (int unsigned l = 0; l < 8; l++) begin
      if (l < nl) begin
        ax = '0;
        bx = '0;
        for (int unsigned i = 0; i < 66; i++) begin
          if (i < w) begin
            ax[i] = a[l*w+i];
            bx[i] = b[l*w+i];
          end else begin
            ax[i] = sgn & a[l*w+w-1];
            bx[i] = sgn & b[l*w+w-1];
          end
        end
        s    = sub ? (ax - bx) : (ax + bx);
        maxv = sgn ? ((66'd1 << (w - 1)) - 66'd1) : ((66'd1 << w) - 66'd1);
        // ~(2^(w-1)-1) is -2^(w-1) in 66-bit two's complement
        minv = sgn ? ~((66'd1 << (w - 1)) - 66'd1) : '0;
        o    = $signed(s) > $signed(maxv);
        u    = $signed(s) < $signed(minv);
        r    = (sat && o) ? maxv : ((sat && u) ? minv : s);
        for (int unsigned i = 0; i < 64; i++) begin
          if (i < w) res[l*w+i] = r[i];
        end
        ovf[l*bpl+bpl-1] = o;
        udf[l*bpl+bpl-1] = u;
      end
    end
    return {udf, ovf, res};
  endfunction

  // Operands/controls feeding the compute + output register stage
  logic                  c_valid;
  logic [DATA_WIDTH-1:0] c_a;
  logic [DATA_WIDTH-1:0] c_b;
  logic [1:0]            c_lane;
  logic                  c_sub;
  logic                  c_sgn;
  logic                  c_sat;
  logic                  adv_out;

  assign adv_out = !out_valid || out_ready;

  generate
    if (PIPE_STAGES >= 2) begin : g_in_stage
      logic                  v0;
      logic [DATA_WIDTH-1:0] a0;
      logic [DATA_WIDTH-1:0] b0;
      logic [1:0]            lane0;
      logic                  sub0;
      logic                  sgn0;
      logic                  sat0;

      assign in_ready = rst_n && (!v0 || adv_out);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v0    <= 1'b0;
          a0    <= '0;
          b0    <= '0;
          lane0 <= '0;
          sub0  <= 1'b0;
          sgn0  <= 1'b0;
          sat0  <= 1'b0;
        end else if (in_ready) begin
          v0 <= in_valid;
          if (in_valid) begin
            a0    <= in_a;
            b0    <= in_b;
            lane0 <= in_lane;
            sub0  <= in_sub;
            sgn0  <= in_signed;
            sat0  <= in_sat;
          end
        end
      end

      assign c_valid = v0;
      assign c_a     = a0;
      assign c_b     = b0;
      assign c_lane  = lane0;
      assign c_sub   = sub0;
      assign c_sgn   = sgn0;
      assign c_sat   = sat0;
    end else begin : g_no_in_stage
      assign in_ready = rst_n && adv_out;
      assign c_valid  = in_valid;
      assign c_a      = in_a;
      assign c_b      = in_b;
      assign c_lane   = in_lane;
      assign c_sub    = in_sub;
      assign c_sgn    = in_signed;
      assign c_sat    = in_sat;
    end
  endgenerate

  logic [DATA_WIDTH-1:0] res_d;
  logic [NB-1:0]         ovf_d;
  logic [NB-1:0]         udf_d;

  always_comb begin
    logic [79:0] cr;
    res_d = '0;
    ovf_d = '0;
    udf_d = '0;
    for (int unsigned c = 0; c < NC; c++) begin
      cr = chunk_op(c_a[c*64 +: 64], c_b[c*64 +: 64], c_lane, c_sub, c_sgn, c_sat);
      res_d[c*64 +: 64] = cr[63:0];
      ovf_d[c*8 +: 8]   = cr[71:64];
      udf_d[c*8 +: 8]   = cr[79:72];
    end
  end

  // Output stage only loads when downstream can take it, so results hold
  // stable through a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= '0;
      out_udf   <= '0;
    end else if (adv_out) begin
      out_valid <= c_valid;
      if (c_valid) begin
        out_data <= res_d;
        out_ovf  <= ovf_d;
        out_udf  <= udf_d;
      end
    end
  end

  // Flags sit only on each lane's top byte, so one bit per flagged lane.
  logic [PW-1:0] flagged;
  logic [SW-1:0] evt_sum;
  logic          evt_full;

  assign flagged  = PW'($countones(out_ovf | out_udf));
  assign evt_sum  = SW'(evt_cnt) + SW'(flagged);
  assign evt_full = evt_sum > SW'({CNT_WIDTH{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt <= '0;
    end else if (evt_clr) begin
      evt_cnt <= '0;
    end else if (out_valid && out_ready) begin
      evt_cnt <= evt_full ? '1 : evt_sum[CNT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_simd_alu_sat_pipe.sv
// -----------------------------------------------------------------------------
// tb_simd_alu_sat_pipe
//   Self-checking bench for simd_alu_sat_pipe. A per-lane integer model
//   predicts each accepted beat; a queue scoreboard checks ordering, the
//   event counter is modelled cycle by cycle.
// -----------------------------------------------------------------------------
module tb_simd_alu_sat_pipe;

  localparam int DW = 256;
  localparam int PS = 2;
  localparam int CW = 16;
  localparam int NB = DW / 8;

  typedef struct {
    logic [DW-1:0] d;
    logic [NB-1:0] o;
    logic [NB-1:0] u;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [1:0]    in_lane = '0;
  logic          in_sub = 1'b0;
  logic          in_signed = 1'b0;
  logic          in_sat = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [NB-1:0] out_ovf;
  logic [NB-1:0] out_udf;
  logic [CW-1:0] evt_cnt;
  logic          evt_clr = 1'b0;

  always #5 clk = ~clk;

  simd_alu_sat_pipe #(
    .DATA_WIDTH (DW),
    .PIPE_STAGES(PS),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_lane  (in_lane),
    .in_sub   (in_sub),
    .in_signed(in_signed),
    .in_sat   (in_sat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .out_udf  (out_udf),
    .evt_cnt  (evt_cnt),
    .evt_clr  (evt_clr)
  );

  int    vectors = 0;
  int    miscompares = 0;
  int    cycle = 0;
  int    acc_cycle = 0;
  int    ov_cycle = 0;
  int    outs = 0;
  int    sent = 0;
  logic  acc = 1'b0;
  logic  ov_seen = 1'b0;
  logic  held_chk = 1'b0;
  beat_t held;
  beat_t last;
  beat_t exp_q[$];
  longint cnt_model = 0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Lane-by-lane exact integer arithmetic, then clamp or wrap.
  function automatic beat_t ref_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                      input logic [1:0] lane, input logic sub,
                                      input logic sgn, input logic sat);
    beat_t r;
    int unsigned w, nl, bpl;
    logic [63:0] m, ua, ub;
    logic signed [127:0] x, y, s, hi, lo, q;
    logic ov, un;
    r.d = '0;
    r.o = '0;
    r.u = '0;
    w   = 8 << lane;
    nl  = DW / w;
    bpl = w / 8;
    m   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    for (int unsigned l = 0; l < nl; l++) begin
      ua = 64'(a >> (l * w)) & m;
      ub = 64'(b >> (l * w)) & m;
      x  = $signed({64'd0, ua});
      y  = $signed({64'd0, ub});
      if (sgn && ua[w-1]) x = x - (128'sd1 <<< w);
      if (sgn && ub[w-1]) y = y - (128'sd1 <<< w);
      s  = sub ? (x - y) : (x + y);
      hi = sgn ? ((128'sd1 <<< (w - 1)) - 128'sd1) : ((128'sd1 <<< w) - 128'sd1);
      lo = sgn ? -(128'sd1 <<< (w - 1)) : 128'sd0;
      ov = s > hi;
      un = s < lo;
      q  = (sat && ov) ? hi : ((sat && un) ? lo : s);
      r.d = r.d | (DW'(q[63:0] & m) << (l * w));
      r.o[l*bpl+bpl-1] = ov;
      r.u[l*bpl+bpl-1] = un;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] lane,
                         input logic sub, input logic sgn, input logic sat);
    in_a = a; in_b = b; in_lane = lane; in_sub = sub; in_signed = sgn; in_sat = sat;
  endtask

  // Bytes biased toward lane edge values so carries/borrows are common.
  task automatic set_rand();
    logic [7:0] pick [4];
    pick[0] = 8'h00; pick[1] = 8'h7F; pick[2] = 8'h80; pick[3] = 8'hFF;
    for (int i = 0; i < NB; i++) begin
      in_a[i*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'($urandom) : pick[$urandom_range(0, 3)];
      in_b[i*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'($urandom) : pick[$urandom_range(0, 3)];
    end
    in_lane   = 2'($urandom_range(0, 3));
    in_sub    = 1'($urandom);
    in_signed = 1'($urandom);
    in_sat    = 1'($urandom);
  endtask

  // One clock: drive at negedge, sample handshakes, cross posedge, check counter.
  task automatic cyc(input logic iv, input logic ordy, input logic clr);
    beat_t e;
    e.d = '0; e.o = '0; e.u = '0;
    in_valid = iv; out_ready = ordy; evt_clr = clr;
    #1;
    acc = iv && in_ready;
    if (held_chk) begin
      check("stall_valid", DW'(out_valid), DW'(1'b1));
      check("stall_data", out_data, held.d);
      check("stall_ovf", DW'(out_ovf), DW'(held.o));
      check("stall_udf", DW'(out_udf), DW'(held.u));
      held_chk = 1'b0;
    end
    if (out_valid && !ov_seen) begin
      ov_seen  = 1'b1;
      ov_cycle = cycle;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", DW'(exp_q.size()), DW'(1));
      end else begin
        e = exp_q.pop_front();
        check("data", out_data, e.d);
        check("ovf", DW'(out_ovf), DW'(e.o));
        check("udf", DW'(out_udf), DW'(e.u));
        last.d = out_data; last.o = out_ovf; last.u = out_udf;
        outs++;
      end
      cnt_model = cnt_model + $countones(e.o | e.u);
      if (cnt_model > 65535) cnt_model = 65535;
    end
    if (clr) cnt_model = 0;
    if (out_valid && !out_ready) begin
      held_chk = 1'b1;
      held.d = out_data; held.o = out_ovf; held.u = out_udf;
    end
    if (acc) begin
      exp_q.push_back(ref_model(in_a, in_b, in_lane, in_sub, in_signed, in_sat));
      acc_cycle = cycle;
    end
    @(posedge clk);
    cycle++;
    @(negedge clk);
    check("evt_cnt", DW'(evt_cnt), DW'(cnt_model));
  endtask

  task automatic flush();
    repeat (PS + 3) cyc(1'b0, 1'b1, 1'b0);
    check("flush_empty", DW'(exp_q.size()), DW'(0));
  endtask

  initial begin
    logic [DW-1:0] a, b;
    logic clr;

    // reset state
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_in_ready", DW'(in_ready), DW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_out_ovf", DW'(out_ovf), DW'(0));
    check("rst_out_udf", DW'(out_udf), DW'(0));
    check("rst_evt_cnt", DW'(evt_cnt), DW'(0));
    @(negedge clk);
    out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", DW'(in_ready), DW'(1));
    @(negedge clk);

    // 8b unsigned add, saturate then wrap
    a = '0; b = '0; a[7:0] = 8'hF0; b[7:0] = 8'h20;
    set_ops(a, b, 2'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    flush();
    check("t1_sat_lane0", DW'(last.d[7:0]), DW'(8'hFF));
    check("t1_sat_ovf", DW'(last.o), DW'(32'h1));
    set_ops(a, b, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    flush();
    check("t1_wrap_lane0", DW'(last.d[7:0]), DW'(8'h10));
    check("t1_wrap_ovf", DW'(last.o), DW'(32'h1));

    // 16b signed sub: underflow lane 0, in-range lane 1
    a = '0; b = '0;
    a[15:0] = 16'h8000; b[15:0] = 16'h0001;
    a[31:16] = 16'h0005; b[31:16] = 16'h0003;
    set_ops(a, b, 2'd1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    flush();
    check("t2_lane0", DW'(last.d[15:0]), DW'(16'h8000));
    check("t2_lane1", DW'(last.d[31:16]), DW'(16'h0002));
    check("t2_udf", DW'(last.u), DW'(32'h2));
    check("t2_ovf", DW'(last.o), DW'(0));

    // 64b signed add overflow
    a = '0; b = '0; a[63:0] = 64'h7FFF_FFFF_FFFF_FFFF; b[63:0] = 64'h1;
    set_ops(a, b, 2'd3, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    flush();
    check("t3_lane0", DW'(last.d[63:0]), DW'(64'h7FFF_FFFF_FFFF_FFFF));
    check("t3_ovf", DW'(last.o), DW'(32'h80));

    // latency with out_ready held high
    ov_seen = 1'b0;
    ov_cycle = -1000;
    set_rand();
    cyc(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (ov_seen) break;
    end
    check("latency", DW'(ov_cycle - acc_cycle), DW'(PS));
    flush();

    // 8-beat stream with out_ready 1,0,0 repeating
    outs = 0; sent = 0;
    set_rand();
    for (int k = 0; k < 100 && sent < 8; k++) begin
      cyc(1'b1, (k % 3) == 0, 1'b0);
      if (acc) begin
        sent++;
        set_rand();
      end
    end
    flush();
    check("t4_sent", DW'(sent), DW'(8));
    check("t4_outs", DW'(outs), DW'(8));

    // all 32 byte lanes overflow; clear coinciding with next such beat
    cyc(1'b0, 1'b1, 1'b1);
    set_ops({NB{8'hFF}}, {NB{8'h01}}, 2'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    flush();
    check("t5_cnt32", DW'(evt_cnt), DW'(32));
    cyc(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      clr = out_valid;
      cyc(1'b0, 1'b1, clr);
      if (clr) break;
    end
    check("t5_clr_wins", DW'(evt_cnt), DW'(0));
    flush();

    // counter saturation
    for (int k = 0; k < 2050; k++) cyc(1'b1, 1'b1, 1'b0);
    flush();
    check("cnt_saturate", DW'(evt_cnt), DW'(16'hFFFF));
    cyc(1'b0, 1'b1, 1'b1);

    // randomized traffic with backpressure and occasional clears
    set_rand();
    for (int k = 0; k < 400; k++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
      if (acc) set_rand();
    end
    flush();

    // reset with two beats in flight
    set_rand();
    cyc(1'b1, 1'b0, 1'b0);
    set_rand();
    cyc(1'b1, 1'b0, 1'b0);
    check("t6_two_in_flight", DW'(exp_q.size()), DW'(2));
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", DW'(out_valid), DW'(0));
    check("t6_rst_in_ready", DW'(in_ready), DW'(0));
    check("t6_rst_evt_cnt", DW'(evt_cnt), DW'(0));
    exp_q.delete();
    cnt_model = 0;
    held_chk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      check("t6_no_stale", DW'(out_valid), DW'(0));
    end
    set_rand();
    cyc(1'b1, 1'b1, 1'b0);
    flush();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
